// File: rtl/tinyriscv_pkg.sv
// Shared bus widths, hold levels and the fetch entry handed to IF/ID.
package tinyriscv_pkg;

    typedef logic [31:0] InstBus;
    typedef logic [31:0] InstAddrBus;
    typedef logic [7:0]  INT_BUS;
    typedef logic [2:0]  Hold_Flag_Bus;

    localparam Hold_Flag_Bus Hold_None    = 3'b000;
    localparam Hold_Flag_Bus Pipe_Hold_Pc = 3'b001;
    localparam Hold_Flag_Bus Pipe_Hold_If = 3'b010;
    localparam Hold_Flag_Bus Pipe_Hold_Id = 3'b011;

    typedef struct packed {
        InstBus     inst;
        InstAddrBus addr;
        InstAddrBus addr_next;
        INT_BUS     int_flag;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with flush, optional fall-through and fill level.
module fifo_v3 #(
    parameter bit FALL_THROUGH = 1'b0,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     usage_o,
    input  logic [DATA_WIDTH-1:0]          data_i,
    input  logic                           push_i,
    output logic [DATA_WIDTH-1:0]          data_o,
    input  logic                           pop_i
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [CW-1:0]         cnt;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty_o = (cnt == '0);
    assign full_o  = (cnt == CW'(DEPTH));
    assign usage_o = cnt;

    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        data_o  = mem[rd_ptr];
        if (FALL_THROUGH && empty_o) begin
            data_o = data_i;
            if (push_i && pop_i) begin
                do_push = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= nxt(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CW'(1);
            end else if (!do_push && do_pop) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, pipelines word fetches and
// queues tagged responses for IF/ID, dropping responses made stale by jumps.
module if_fetch_unit
    import tinyriscv_pkg::*;
#(
    parameter InstAddrBus BOOT_ADDR       = 32'h0000_0000,
    parameter int         MAX_OUTSTANDING = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         jump_flag_i,
    input  InstAddrBus   jump_addr_i,
    input  Hold_Flag_Bus hold_flag_i,
    input  INT_BUS       int_flag_i,
    output logic         mem_req_o,
    output InstAddrBus   mem_addr_o,
    input  logic         mem_gnt_i,
    input  logic         mem_rvalid_i,
    input  InstBus       mem_rdata_i,
    output logic         instr_ready_o,
    input  logic         instr_req_i,
    output InstBus       inst_o,
    output InstAddrBus   inst_addr_o,
    output InstAddrBus   inst_addr_next_o,
    output INT_BUS       int_flag_o
);

    localparam int CW = 4;
    localparam int UW = $clog2(MAX_OUTSTANDING + 1);

    InstAddrBus    pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic          req_pending;
    logic          hold;
    logic          gnt;
    logic          drop;
    logic          resp_push;
    logic          resp_pop;

    InstAddrBus    rsp_addr;
    logic          addr_full;
    logic          addr_empty;
    logic [UW-1:0] addr_usage;
    logic          resp_full;
    logic          resp_empty;
    logic [UW-1:0] resp_usage;
    fetch_entry_t  resp_in;
    fetch_entry_t  resp_head;

    assign hold = (hold_flag_i >= Pipe_Hold_Pc);

    // A pending request is never withdrawn by hold; only a jump kills it.
    assign mem_req_o = !rst_i && !jump_flag_i && !(hold && !req_pending)
                     && ((outstanding + CW'(resp_usage)) < CW'(MAX_OUTSTANDING));
    assign mem_addr_o = pc;

    assign gnt       = mem_req_o && mem_gnt_i;
    assign drop      = mem_rvalid_i && (discard != '0);
    assign resp_push = mem_rvalid_i && !drop && !jump_flag_i;
    assign resp_pop  = instr_ready_o && instr_req_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc          <= BOOT_ADDR;
            outstanding <= '0;
            discard     <= '0;
            req_pending <= 1'b0;
        end else begin
            req_pending <= mem_req_o && !mem_gnt_i;
            outstanding <= outstanding + CW'(gnt) - CW'(mem_rvalid_i);
            if (jump_flag_i) begin
                pc      <= jump_addr_i;
                discard <= outstanding + CW'(gnt) - CW'(mem_rvalid_i);
            end else begin
                if (gnt) begin
                    pc <= pc + 32'd4;
                end
                if (drop) begin
                    discard <= discard - CW'(1);
                end
            end
        end
    end

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   ($bits(InstAddrBus)),
        .DEPTH        (MAX_OUTSTANDING)
    ) u_addr_q (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (1'b0),
        .full_o  (addr_full),
        .empty_o (addr_empty),
        .usage_o (addr_usage),
        .data_i  (pc),
        .push_i  (gnt),
        .data_o  (rsp_addr),
        .pop_i   (mem_rvalid_i)
    );

    assign resp_in = '{
        inst:      mem_rdata_i,
        addr:      rsp_addr,
        addr_next: rsp_addr + 32'd4,
        int_flag:  int_flag_i
    };

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (FETCH_ENTRY_W),
        .DEPTH        (MAX_OUTSTANDING)
    ) u_resp_q (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (jump_flag_i),
        .full_o  (resp_full),
        .empty_o (resp_empty),
        .usage_o (resp_usage),
        .data_i  (resp_in),
        .push_i  (resp_push),
        .data_o  (resp_head),
        .pop_i   (resp_pop)
    );

    assign instr_ready_o    = !resp_empty;
    assign inst_o           = instr_ready_o ? resp_head.inst      : '0;
    assign inst_addr_o      = instr_ready_o ? resp_head.addr      : '0;
    assign inst_addr_next_o = instr_ready_o ? resp_head.addr_next : '0;
    assign int_flag_o       = instr_ready_o ? resp_head.int_flag  : '0;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(mem_rvalid_i && outstanding == '0));
            assert (!(mem_rvalid_i && addr_empty));
            assert (!(gnt && addr_full));
            assert (!(resp_push && resp_full));
            assert (CW'(addr_usage) == outstanding);
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized and directed bench for if_fetch_unit against a queue model.
module tb_if_fetch_unit;
    import tinyriscv_pkg::*;

    localparam int MAXO = 2;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         jump_flag_i;
    InstAddrBus   jump_addr_i;
    Hold_Flag_Bus hold_flag_i;
    INT_BUS       int_flag_i;
    logic         mem_req_o;
    InstAddrBus   mem_addr_o;
    logic         mem_gnt_i;
    logic         mem_rvalid_i;
    InstBus       mem_rdata_i;
    logic         instr_ready_o;
    logic         instr_req_i;
    InstBus       inst_o;
    InstAddrBus   inst_addr_o;
    InstAddrBus   inst_addr_next_o;
    INT_BUS       int_flag_o;

    if_fetch_unit #(
        .BOOT_ADDR       (32'h0000_0000),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .jump_flag_i      (jump_flag_i),
        .jump_addr_i      (jump_addr_i),
        .hold_flag_i      (hold_flag_i),
        .int_flag_i       (int_flag_i),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_gnt_i        (mem_gnt_i),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rdata_i      (mem_rdata_i),
        .instr_ready_o    (instr_ready_o),
        .instr_req_i      (instr_req_i),
        .inst_o           (inst_o),
        .inst_addr_o      (inst_addr_o),
        .inst_addr_next_o (inst_addr_next_o),
        .int_flag_o       (int_flag_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } fl_t;

    fl_t          inflight[$];
    fetch_entry_t respq[$];
    fetch_entry_t got[$];
    logic [31:0]  gaddr[$];
    logic [31:0]  m_pc;
    bit           m_pend;
    bit           last_req;
    int           vectors = 0;
    int           errors  = 0;
    int           cyc;
    int           first_gnt;
    int           first_rdy;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic bit m_req(input bit j, input logic [2:0] h);
        return !j && !(h >= Pipe_Hold_Pc && !m_pend)
            && (inflight.size() + respq.size() < MAXO);
    endfunction

    task automatic do_reset();
        rst_i        = 1'b1;
        jump_flag_i  = 1'b0;
        jump_addr_i  = '0;
        hold_flag_i  = '0;
        int_flag_i   = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        instr_req_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
        chk("rst_ready", {31'b0, instr_ready_o}, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_addr", inst_addr_o, 32'd0);
        chk("rst_addr_next", inst_addr_next_o, 32'd0);
        chk("rst_int", {24'b0, int_flag_o}, 32'd0);
        rst_i = 1'b0;
        m_pc  = 32'h0;
        m_pend = 1'b0;
        inflight.delete();
        respq.delete();
        got.delete();
        gaddr.delete();
        cyc = 0;
        first_gnt = -1;
        first_rdy = -1;
    endtask

    task automatic step(input bit j, input logic [31:0] ja,
                        input logic [2:0] h, input bit g, input bit rv,
                        input bit ir, input logic [31:0] rd,
                        input logic [7:0] intf);
        bit           req;
        fl_t          f;
        fetch_entry_t e;
        if (inflight.size() == 0) rv = 1'b0;
        jump_flag_i  = j;
        jump_addr_i  = ja;
        hold_flag_i  = h;
        mem_gnt_i    = g;
        mem_rvalid_i = rv;
        mem_rdata_i  = rd;
        instr_req_i  = ir;
        int_flag_i   = intf;
        #1;
        req = m_req(j, h);
        last_req = mem_req_o;
        chk("mem_req", {31'b0, mem_req_o}, {31'b0, req});
        if (req) chk("mem_addr", mem_addr_o, m_pc);
        if (instr_ready_o && ir) begin
            e.inst      = inst_o;
            e.addr      = inst_addr_o;
            e.addr_next = inst_addr_next_o;
            e.int_flag  = int_flag_o;
            got.push_back(e);
        end
        if (req && g) begin
            gaddr.push_back(m_pc);
            if (first_gnt < 0) first_gnt = cyc;
        end
        @(posedge clk_i);
        cyc++;
        if (respq.size() > 0 && ir) void'(respq.pop_front());
        if (rv) begin
            f = inflight.pop_front();
            if (!f.stale) begin
                e.inst      = rd;
                e.addr      = f.addr;
                e.addr_next = f.addr + 32'd4;
                e.int_flag  = intf;
                respq.push_back(e);
            end
        end
        if (req && g) begin
            f.addr  = m_pc;
            f.stale = 1'b0;
            inflight.push_back(f);
            m_pc = m_pc + 32'd4;
        end
        if (j) begin
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            respq.delete();
            m_pc = ja;
        end
        m_pend = req && !g;
        #1;
        chk("instr_ready", {31'b0, instr_ready_o},
            {31'b0, respq.size() > 0});
        if (respq.size() > 0) begin
            chk("inst", inst_o, respq[0].inst);
            chk("inst_addr", inst_addr_o, respq[0].addr);
            chk("inst_addr_next", inst_addr_next_o, respq[0].addr_next);
            chk("int_flag", {24'b0, int_flag_o}, {24'b0, respq[0].int_flag});
        end
        if (instr_ready_o && first_rdy < 0) first_rdy = cyc;
    endtask

    // 1-cycle memory: grant always, respond on the next cycle.
    task automatic mem1(input int n, input bit ir);
        for (int k = 0; k < n; k++) step(0, 0, 0, 1, 1, ir, 32'h13, 0);
    endtask

    initial begin
        // Streaming from boot address
        do_reset();
        mem1(8, 1);
        chk("t1_addr0", got[0].addr, 32'h0);
        chk("t1_next0", got[0].addr_next, 32'h4);
        chk("t1_inst0", got[0].inst, 32'h13);
        chk("t1_addr1", got[1].addr, 32'h4);
        chk("t1_next1", got[1].addr_next, 32'h8);
        chk("t1_gaddr1", gaddr[1], 32'h4);
        chk("t1_latency", first_rdy - first_gnt, 32'd2);

        // Back-pressure: only two fetches, then delivered in order
        do_reset();
        mem1(10, 0);
        chk("t2_grants", gaddr.size(), 32'd2);
        mem1(4, 1);
        chk("t2_addr0", got[0].addr, 32'h0);
        chk("t2_addr1", got[1].addr, 32'h4);

        // Jump with two requests in flight
        do_reset();
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, 1, 32'h13, 0);
        step(1, 32'h100, 0, 1, 0, 1, 32'h13, 0);
        mem1(10, 1);
        chk("t3_addr", got[0].addr, 32'h100);
        chk("t3_next", got[0].addr_next, 32'h104);

        // Jump coinciding with gnt and rvalid
        do_reset();
        mem1(3, 1);
        step(1, 32'h200, 0, 1, 1, 1, 32'h13, 0);
        got.delete();
        mem1(10, 1);
        chk("t4_addr", got[0].addr, 32'h200);

        // Hold freezes new fetches but not a pending one
        do_reset();
        step(0, 0, 1, 0, 0, 1, 0, 0);
        chk("t5_hold_idle", {31'b0, last_req}, 32'd0);
        step(0, 0, 1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk("t5_req", {31'b0, last_req}, 32'd1);
        step(0, 0, 1, 0, 0, 1, 0, 0);
        chk("t5_hold_pend", {31'b0, last_req}, 32'd1);
        step(0, 0, 1, 1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 1, 1, 32'h13, 0);
        chk("t5_hold_after", {31'b0, last_req}, 32'd0);
        chk("t5_gaddr", gaddr[0], 32'h0);
        mem1(4, 1);

        // PC wrap and interrupt capture
        do_reset();
        step(1, 32'hFFFF_FFFC, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 6; k++)
            step(0, 0, 0, 1, 1, 1, 32'h13, (k == 1) ? 8'h01 : 8'h00);
        chk("t6_gaddr0", gaddr[0], 32'hFFFF_FFFC);
        chk("t6_gaddr1", gaddr[1], 32'h0);
        chk("t6_next", got[0].addr_next, 32'h0);
        chk("t6_int0", {24'b0, got[0].int_flag}, 32'h01);
        chk("t6_int1", {24'b0, got[1].int_flag}, 32'h00);

        // Random traffic
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(99) < 5,
                 $urandom & 32'hFFFF_FFFC,
                 ($urandom_range(99) < 15) ? 3'($urandom_range(1, 3)) : 3'd0,
                 $urandom_range(99) < 60,
                 $urandom_range(99) < 50,
                 $urandom_range(99) < 70,
                 $urandom,
                 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
